// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: branch flush, multi-cycle vector stall,
// load-use bubble and halt/resume, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int VEC_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_taken,
    input  logic             vec_start,
    input  logic             load_use,
    input  logic             halt,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             vec_busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_VEC_BUSY = 2'b10;
    localparam logic [1:0] ST_HALTED   = 2'b11;
    // The vector start cycle is itself a stall, so the counter covers the rest.
    localparam logic [7:0] VEC_LOAD    = 8'(VEC_CYCLES - 1);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_next_s;
    logic [CNT_W-1:0] stall_count_r;

    // Output decode and next-state logic; reset forces the RUN defaults.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_clr     = 1'b0;
        idex_clr     = 1'b0;
        exmem_clr    = 1'b0;
        vec_busy     = 1'b0;
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        if (reset) begin
            next_state_s = ST_RUN;
            cnt_next_s   = 8'd0;
        end else begin
            case (state_r)
                ST_RUN, 2'b01: begin
                    next_state_s = ST_RUN;
                    if (branch_taken) begin
                        ifid_clr = 1'b1;
                        idex_clr = 1'b1;
                    end else if (vec_start) begin
                        if (VEC_CYCLES > 32'sd1) begin
                            pc_en        = 1'b0;
                            ifid_en      = 1'b0;
                            idex_en      = 1'b0;
                            exmem_en     = 1'b0;
                            exmem_clr    = 1'b1;
                            vec_busy     = 1'b1;
                            cnt_next_s   = VEC_LOAD;
                            next_state_s = ST_VEC_BUSY;
                        end else begin
                            cnt_next_s = 8'd0;
                        end
                    end else if (halt) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_en     = 1'b0;
                        next_state_s = ST_HALTED;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_clr = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_VEC_BUSY: begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_en  = 1'b0;
                    exmem_clr = 1'b1;
                    vec_busy  = 1'b1;
                    if (cnt_r <= 8'd1) begin
                        cnt_next_s   = 8'd0;
                        next_state_s = ST_RUN;
                    end else begin
                        cnt_next_s   = cnt_r - 8'd1;
                        next_state_s = ST_VEC_BUSY;
                    end
                end
                ST_HALTED: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    if (resume) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_HALTED;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                    cnt_next_s   = 8'd0;
                end
            endcase
        end
    end

    // State, vector countdown and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_RUN;
            cnt_r         <= 8'd0;
            stall_count_r <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            if (!pc_en && (state_r != ST_HALTED) && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end
        end
    end

    assign state       = state_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: default configuration plus
// a VEC_CYCLES=1 / CNT_W=3 instance for the no-stall and saturation corners.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset, branch_taken, vec_start, load_use, halt, resume;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_clr, idex_clr, exmem_clr, vec_busy;
    logic [1:0]  state;
    logic [15:0] stall_count;

    logic pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
    logic ifid_clr_b, idex_clr_b, exmem_clr_b, vec_busy_b;
    logic [1:0] state_b;
    logic [2:0] stall_count_b;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    wire [4:0] ens  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [2:0] clrs = {ifid_clr, idex_clr, exmem_clr};

    always #5 clk = ~clk;

    pipeline_ctrl #(.VEC_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .vec_start(vec_start),
        .load_use(load_use), .halt(halt), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .vec_busy(vec_busy), .state(state), .stall_count(stall_count)
    );

    pipeline_ctrl #(.VEC_CYCLES(1), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .vec_start(vec_start),
        .load_use(load_use), .halt(halt), .resume(resume),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
        .memwb_en(memwb_en_b), .ifid_clr(ifid_clr_b), .idex_clr(idex_clr_b),
        .exmem_clr(exmem_clr_b), .vec_busy(vec_busy_b), .state(state_b),
        .stall_count(stall_count_b)
    );

    task automatic clear_inputs();
        branch_taken = 1'b0;
        vec_start    = 1'b0;
        load_use     = 1'b0;
        halt         = 1'b0;
        resume       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        branch_taken = 1'b1;
        halt         = 1'b1;
        load_use     = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ens !== 5'b11111) begin n_fail++; $display("FAIL reset_hold_ens got %b want %b", ens, 5'b11111); end
        n_checks++;
        if (clrs !== 3'b000) begin n_fail++; $display("FAIL reset_hold_clrs got %b want %b", clrs, 3'b000); end
        n_checks++;
        if (vec_busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_vec_busy got %b want 0", vec_busy); end
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (ens !== 5'b11111) begin n_fail++; $display("FAIL idle_ens got %b want %b", ens, 5'b11111); end
        n_checks++;
        if (clrs !== 3'b000) begin n_fail++; $display("FAIL idle_clrs got %b want %b", clrs, 3'b000); end
        n_checks++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL idle_state got %b want 00", state); end
        n_checks++;
        if (stall_count !== 16'd0) begin n_fail++; $display("FAIL idle_stall got %0d want 0", stall_count); end
        exp_stall = 0;
    endtask

    task automatic test_vec_stall();
        logic       exp_pc;
        logic [1:0] exp_st;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vec_start    = (i == 0);
            branch_taken = (i >= 1 && i <= 3);
            load_use     = (i >= 1 && i <= 3);
            #1;
            exp_pc = (i < 4) ? 1'b0 : 1'b1;
            exp_st = (i >= 1 && i <= 3) ? 2'b10 : 2'b00;
            n_checks++;
            if (pc_en !== exp_pc) begin n_fail++; $display("FAIL vec_pc_en[%0d] got %b want %b", i, pc_en, exp_pc); end
            n_checks++;
            if (state !== exp_st) begin n_fail++; $display("FAIL vec_state[%0d] got %b want %b", i, state, exp_st); end
            n_checks++;
            if (vec_busy !== ~exp_pc) begin n_fail++; $display("FAIL vec_busy[%0d] got %b want %b", i, vec_busy, ~exp_pc); end
            n_checks++;
            if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL vec_stall[%0d] got %0d want %0d", i, stall_count, exp_stall); end
            if (i < 4) begin
                n_checks++;
                if (ens !== 5'b00001 || clrs !== 3'b001) begin
                    n_fail++; $display("FAIL vec_outputs[%0d] got ens %b clrs %b want 00001 001", i, ens, clrs);
                end
                exp_stall++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        @(negedge clk);
        branch_taken = 1'b1;
        load_use     = 1'b1;
        vec_start    = 1'b1;
        #1;
        n_checks++;
        if (ens !== 5'b11111) begin n_fail++; $display("FAIL branch_ens got %b want %b", ens, 5'b11111); end
        n_checks++;
        if (clrs !== 3'b110) begin n_fail++; $display("FAIL branch_clrs got %b want %b", clrs, 3'b110); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL branch_state got %b want 00", state); end
        n_checks++;
        if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL branch_stall got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        load_use = 1'b1;
        #1;
        n_checks++;
        if (ens !== 5'b00111) begin n_fail++; $display("FAIL lu_ens got %b want %b", ens, 5'b00111); end
        n_checks++;
        if (clrs !== 3'b010) begin n_fail++; $display("FAIL lu_clrs got %b want %b", clrs, 3'b010); end
        exp_stall++;
        @(negedge clk);
        load_use = 1'b0;
        #1;
        n_checks++;
        if (ens !== 5'b11111 || clrs !== 3'b000) begin
            n_fail++; $display("FAIL lu_after got ens %b clrs %b want 11111 000", ens, clrs);
        end
        n_checks++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL lu_state got %b want 00", state); end
        n_checks++;
        if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_stall got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_halt_from_vec();
        logic [1:0] st_tab  [0:9];
        logic [4:0] ens_tab [0:9];
        st_tab  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        ens_tab = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000,
                    5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_start = (i == 0);
            halt      = (i >= 2 && i <= 7);
            resume    = (i == 8);
            #1;
            n_checks++;
            if (state !== st_tab[i]) begin n_fail++; $display("FAIL halt_state[%0d] got %b want %b", i, state, st_tab[i]); end
            n_checks++;
            if (ens !== ens_tab[i]) begin n_fail++; $display("FAIL halt_ens[%0d] got %b want %b", i, ens, ens_tab[i]); end
            n_checks++;
            if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL halt_stall[%0d] got %0d want %0d", i, stall_count, exp_stall); end
            if (i >= 4 && i <= 8) begin
                n_checks++;
                if (clrs !== 3'b000) begin n_fail++; $display("FAIL halt_clrs[%0d] got %b want 000", i, clrs); end
            end
            if (i <= 4) exp_stall++;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_vec();
        @(negedge clk);
        vec_start = 1'b1;
        @(negedge clk);
        vec_start = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (state !== 2'b10) begin n_fail++; $display("FAIL rst_vec_pre_state got %b want 10", state); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL rst_vec_state got %b want 00", state); end
        n_checks++;
        if (pc_en !== 1'b1 || vec_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_vec_out got pc_en %b vec_busy %b want 1 0", pc_en, vec_busy);
        end
        n_checks++;
        if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_vec_stall got %0d want 0", stall_count); end
        exp_stall = 0;
        @(negedge clk);
        reset    = 1'b0;
        load_use = 1'b1;
        #1;
        n_checks++;
        if (ens !== 5'b00111) begin n_fail++; $display("FAIL post_rst_lu_ens got %b want %b", ens, 5'b00111); end
        exp_stall++;
        @(negedge clk);
        load_use = 1'b0;
        #1;
        n_checks++;
        if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL post_rst_stall got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_small_cfg();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset     = 1'b0;
        vec_start = 1'b1;
        #1;
        n_checks++;
        if (pc_en_b !== 1'b1 || vec_busy_b !== 1'b0) begin
            n_fail++; $display("FAIL vec1_out got pc_en %b vec_busy %b want 1 0", pc_en_b, vec_busy_b);
        end
        @(negedge clk);
        vec_start = 1'b0;
        #1;
        n_checks++;
        if (state_b !== 2'b00 || stall_count_b !== 3'd0) begin
            n_fail++; $display("FAIL vec1_state got state %b stall %0d want 00 0", state_b, stall_count_b);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            load_use = 1'b1;
            #1;
            if (i == 6) begin
                n_checks++;
                if (stall_count_b !== 3'd6) begin n_fail++; $display("FAIL sat_mid got %0d want 6", stall_count_b); end
            end
        end
        @(negedge clk);
        load_use = 1'b0;
        #1;
        n_checks++;
        if (stall_count_b !== 3'd7) begin n_fail++; $display("FAIL sat_final got %0d want 7", stall_count_b); end
    endtask

    initial begin
        test_reset();
        test_vec_stall();
        test_branch_priority();
        test_load_use();
        test_halt_from_vec();
        test_reset_mid_vec();
        test_small_cfg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_CYCLES, default 4, giving the total EX-stage occupancy in cycles of a vector op; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port branch_taken, input, 1 bit: the instruction in EX redirects the PC this cycle.
REQ-006 The block SHALL have port vec_start, input, 1 bit: the instruction in EX is a multi-cycle vector op.
REQ-007 The block SHALL have port load_use, input, 1 bit: decode detects a load-use hazard.
REQ-008 The block SHALL have ports halt and resume, input, 1 bit each: level halt request and resume pulse.
REQ-009 The block SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 bit each: enables for the PC and pipeline registers.
REQ-010 The block SHALL have ports ifid_clr, idex_clr and exmem_clr, output, 1 bit each: synchronous clears (bubble insert) for the pipeline registers.
REQ-011 The block SHALL have ports vec_busy (output, 1 bit), state (output, 2 bits) and stall_count (output, CNT_W bits).

Function
REQ-012 The FSM SHALL have states RUN=2'b00, VEC_BUSY=2'b10 and HALTED=2'b11; 2'b01 is unused and SHALL map to RUN.
REQ-013 Outputs SHALL be combinational from the state, the down-counter and the inputs; state, counter and stall_count SHALL be registered.
REQ-014 In RUN, the default outputs SHALL be all enables 1 and all clears 0.
REQ-015 In RUN, input priority SHALL be branch_taken > vec_start > halt > load_use; lower-priority inputs are ignored that cycle.
REQ-016 branch_taken in RUN SHALL assert ifid_clr=1 and idex_clr=1, leave all enables 1, and keep the state RUN.
REQ-017 vec_start in RUN with VEC_CYCLES>1 SHALL drive pc_en=ifid_en=idex_en=exmem_en=0, exmem_clr=1, memwb_en=1 and vec_busy=1, load cnt<=VEC_CYCLES-1, and move next to VEC_BUSY.
REQ-018 With VEC_CYCLES=1, vec_start SHALL produce no stall and the state SHALL remain RUN.
REQ-019 VEC_BUSY SHALL drive the same outputs as REQ-017 and decrement cnt each cycle; when cnt==1 the next state SHALL be RUN, giving exactly VEC_CYCLES stall cycles in total.
REQ-020 In VEC_BUSY, branch_taken, vec_start, load_use and halt SHALL be ignored; a halt still asserted on return to RUN SHALL be honoured then.
REQ-021 load_use in RUN SHALL drive pc_en=0, ifid_en=0 and idex_clr=1 for that cycle only, with no state change.
REQ-022 halt in RUN SHALL drive all enables 0 and all clears 0 that cycle, and move next to HALTED.
REQ-023 HALTED SHALL drive all enables 0 and all clears 0; resume=1 SHALL return the state to RUN on the next edge, with outputs in the resume cycle still 0.
REQ-024 stall_count SHALL increment on every cycle with pc_en=0 while not in HALTED (including the halt-request cycle), and SHALL saturate at all-ones.

Reset
REQ-025 Asserting reset SHALL immediately set state=RUN, cnt=0 and stall_count=0, including mid-VEC_BUSY or in HALTED.
REQ-026 While reset is high, the outputs SHALL equal the RUN defaults (enables 1, clears 0, vec_busy 0) regardless of the inputs.
REQ-027 After reset deasserts, the first edge SHALL be a normal RUN cycle.

Verification
REQ-028 Reset, then idle for 5 cycles -> all enables 1, all clears 0, state=00, stall_count=0.
REQ-029 VEC_CYCLES=4, vec_start pulsed 1 cycle -> pc_en=0 for exactly 4 cycles, state 10 for 3 cycles, then 00, stall_count=4.
REQ-030 branch_taken=1 together with load_use=1 and vec_start=1 -> ifid_clr=idex_clr=1, pc_en=1, state stays 00, stall_count unchanged.
REQ-031 load_use=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle only, stall_count=1.
REQ-032 halt held from mid-VEC_BUSY -> HALTED entered 1 cycle after VEC_BUSY exits; resume pulse -> state 00 next cycle; stall_count frozen while HALTED.
REQ-033 reset asserted at VEC_BUSY cnt=2 -> state=00 and pc_en=1 asynchronously, before the next clock edge.
